mem_bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the shared memory-mapped bus: RAM at addr[15]=1, ROM at addr[15:14]=00, TTY at 16'h4000.
- Master 0 is the CPU; master 1 is a DMA/peripheral port.
- Grants the bus round-robin with a bounded hold, decodes the slave enable, drives rd/wr strobes and waits out synchronous read latency.
- Returns data, ack or error to the granted master.

---
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the shared slave bus.
// The arbiter uses the slave modport; the master modport is the requesters' and slaves' side.
interface mem_bus_arbiter_if;
  logic        m0_req;
  logic        m1_req;
  logic        m0_wr;
  logic        m1_wr;
  logic [15:0] m0_addr;
  logic [15:0] m1_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m1_wdata;
  logic        m0_ack;
  logic        m1_ack;
  logic [31:0] m0_rdata;
  logic [31:0] m1_rdata;
  logic        m0_err;
  logic        m1_err;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        mem_en;
  logic        rom_en;
  logic        tty_en;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata,
    output m0_ack, m1_ack, m0_rdata, m1_rdata, m0_err, m1_err,
    output bus_addr, bus_wdata, bus_rd, bus_wr, mem_en, rom_en, tty_en
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata, m0_err, m1_err,
    input  bus_addr, bus_wdata, bus_rd, bus_wr, mem_en, rom_en, tty_en
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter with bounded hold, slave decode and read-latency sequencing
// for the shared RAM/ROM/TTY bus.
module mem_bus_arbiter #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_HOLD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0][31:0] rdata_q, rdata_d;

  logic             own_req, other_req, own_wr;
  logic [15:0]      own_addr;
  logic [31:0]      own_wdata;
  logic             is_mem, is_rom, is_tty;
  logic             done, rd_ack, err, start_rd, advance;
  logic [31:0]      rd_val;
  logic             hold_full;
  logic [HoldW-1:0] hold_inc;

  assign own_req   = owner_q ? bus.m1_req   : bus.m0_req;
  assign other_req = owner_q ? bus.m0_req   : bus.m1_req;
  assign own_wr    = owner_q ? bus.m1_wr    : bus.m0_wr;
  assign own_addr  = owner_q ? bus.m1_addr  : bus.m0_addr;
  assign own_wdata = owner_q ? bus.m1_wdata : bus.m0_wdata;

  assign is_mem = own_addr[15];
  assign is_rom = (own_addr[15:14] == 2'b00);
  assign is_tty = (own_addr == 16'h4000);

  // hold_cnt only advances while the other master is waiting, so it bounds its wait
  assign hold_full = (32'(hold_q) + 32'd1) >= MAX_HOLD;
  assign hold_inc  = (32'(hold_q) < MAX_HOLD) ? hold_q + HoldW'(1) : hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      hold_q       <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    advance      = 1'b0;
    if (rd_ack) rdata_d[owner_q] = rd_val;
    unique case (state_q)
      StIdle: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d = StIssue;
          hold_d  = '0;
          owner_d = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
        end
      end
      StIssue: begin
        if (own_req) begin
          last_grant_d = owner_q;
          addr_d       = own_addr;
          wdata_d      = own_wdata;
        end
        if (start_rd) begin
          state_d = StWait;
          cnt_d   = 3'(RD_LATENCY);
        end else begin
          advance = 1'b1;
        end
      end
      StWait: begin
        cnt_d   = cnt_q - 3'd1;
        advance = done;
      end
      default: state_d = StIdle;
    endcase
    // Re-arbitrate in the completion cycle so back-to-back issues cost no extra cycle
    if (advance) begin
      if (other_req && hold_full) begin
        owner_d = ~owner_q;
        hold_d  = '0;
        state_d = StIssue;
      end else if (own_req) begin
        hold_d  = other_req ? hold_inc : '0;
        state_d = StIssue;
      end else if (other_req) begin
        owner_d = ~owner_q;
        hold_d  = '0;
        state_d = StIssue;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    start_rd      = 1'b0;
    done          = 1'b0;
    rd_ack        = 1'b0;
    err           = 1'b0;
    rd_val        = '0;
    bus.bus_rd    = 1'b0;
    bus.bus_wr    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.rom_en    = 1'b0;
    bus.tty_en    = 1'b0;
    bus.bus_addr  = addr_q;
    bus.bus_wdata = wdata_q;
    unique case (state_q)
      StIssue: begin
        if (own_req) begin
          bus.bus_addr  = own_addr;
          bus.bus_wdata = own_wdata;
          if (!own_wr && (is_mem || is_rom)) begin
            start_rd   = 1'b1;
            bus.bus_rd = 1'b1;
            bus.mem_en = is_mem;
            bus.rom_en = is_rom;
          end else if (own_wr && (is_mem || is_tty)) begin
            done       = 1'b1;
            bus.bus_wr = 1'b1;
            bus.mem_en = is_mem;
            bus.tty_en = is_tty;
          end else if (!own_wr && is_tty) begin
            done   = 1'b1;
            rd_ack = 1'b1;
          end else begin
            done = 1'b1;
            err  = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 3'd1) begin
          done   = 1'b1;
          rd_ack = 1'b1;
          rd_val = bus.bus_rdata;
        end
      end
      default: ;
    endcase
    bus.m0_ack   = done & ~owner_q;
    bus.m1_ack   = done & owner_q;
    bus.m0_err   = err & ~owner_q;
    bus.m1_err   = err & owner_q;
    bus.m0_rdata = (rd_ack && !owner_q) ? rd_val : rdata_q[0];
    bus.m1_rdata = (rd_ack && owner_q) ? rd_val : rdata_q[1];
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: dut_a (RD_LATENCY=2, MAX_HOLD=4) with a small latency-2 slave model,
// dut_b (RD_LATENCY=1, MAX_HOLD=1) for strict alternation.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if if_a ();
  mem_bus_arbiter_if if_b ();

  mem_bus_arbiter #(.RD_LATENCY(2), .MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mem_bus_arbiter #(.RD_LATENCY(1), .MAX_HOLD(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int n_checks = 0;
  int n_errors = 0;

  // Slave model: 16-word store indexed by addr[3:0], read data valid 2 cycles after bus_rd
  logic [31:0] mem_a [16] = '{default: 32'h0};
  logic        rd_n = 1'b0;
  logic [15:0] addr_n = 16'h0;
  logic [1:0]  pipe = 2'b00;
  logic [31:0] lat_data = 32'h0;

  always @(negedge clk) begin
    rd_n   = if_a.bus_rd;
    addr_n = if_a.bus_addr;
    if (if_a.bus_wr && if_a.mem_en) mem_a[if_a.bus_addr[3:0]] = if_a.bus_wdata;
  end

  always @(posedge clk) begin
    pipe <= {pipe[0], rd_n};
    if (rd_n) lat_data <= mem_a[addr_n[3:0]];
  end

  assign if_a.bus_rdata = pipe[1] ? lat_data : 32'h0;
  assign if_b.bus_rdata = 32'h0;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    int          n_rd;
    int          n_wr;
    logic [2:0]  en;
    logic [15:0] saddr;
    logic [31:0] swdata;
    int          s_cyc;
    int          a_cyc;
  } txn_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({if_a.m0_ack, if_a.m1_ack, if_a.m0_err, if_a.m1_err, if_a.bus_rd,
                               if_a.bus_wr, if_a.mem_en, if_a.rom_en, if_a.tty_en}), 32'h0);
    check({tag, "_rd0"}, if_a.m0_rdata, 32'h0);
    check({tag, "_rd1"}, if_a.m1_rdata, 32'h0);
    check({tag, "_addr"}, 32'(if_a.bus_addr), 32'h0);
    check({tag, "_wdata"}, if_a.bus_wdata, 32'h0);
  endtask

  // Called just after a posedge with dut_a idle; returns one cycle after the req drop
  task automatic run_txn(input logic m, input logic wr, input logic [15:0] addr,
                         input logic [31:0] wdata, output txn_t r);
    r.ack = 1'b0; r.err = 1'b0; r.rdata = '0; r.n_rd = 0; r.n_wr = 0; r.en = '0;
    r.saddr = '0; r.swdata = '0; r.s_cyc = -1; r.a_cyc = -1;
    if (!m) begin
      if_a.m0_req = 1'b1; if_a.m0_wr = wr; if_a.m0_addr = addr; if_a.m0_wdata = wdata;
    end else begin
      if_a.m1_req = 1'b1; if_a.m1_wr = wr; if_a.m1_addr = addr; if_a.m1_wdata = wdata;
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      r.en = r.en | {if_a.tty_en, if_a.rom_en, if_a.mem_en};
      if (if_a.bus_rd || if_a.bus_wr) begin
        r.n_rd   += int'(if_a.bus_rd);
        r.n_wr   += int'(if_a.bus_wr);
        r.saddr  = if_a.bus_addr;
        r.swdata = if_a.bus_wdata;
        r.s_cyc  = c;
      end
      if (m ? if_a.m1_ack : if_a.m0_ack) begin
        r.ack   = 1'b1;
        r.err   = m ? if_a.m1_err : if_a.m0_err;
        r.rdata = m ? if_a.m1_rdata : if_a.m0_rdata;
        r.a_cyc = c;
        break;
      end
    end
    @(posedge clk); #1;
    if (!m) if_a.m0_req = 1'b0;
    else if_a.m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    txn_t       r;
    logic [1:0] seq [5];
    int         n0;
    logic       got1;
    logic       seen;

    {if_a.m0_req, if_a.m1_req, if_a.m0_wr, if_a.m1_wr} = '0;
    {if_a.m0_addr, if_a.m1_addr, if_a.m0_wdata, if_a.m1_wdata} = '0;
    {if_b.m0_req, if_b.m1_req, if_b.m0_wr, if_b.m1_wr} = '0;
    {if_b.m0_addr, if_b.m1_addr, if_b.m0_wdata, if_b.m1_wdata} = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Simultaneous writes with MAX_HOLD=1 alternate, m0 first
    if_b.m0_req = 1'b1; if_b.m0_wr = 1'b1; if_b.m0_addr = 16'h8000;
    if_b.m1_req = 1'b1; if_b.m1_wr = 1'b1; if_b.m1_addr = 16'h8001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      seq[c] = {if_b.m1_ack, if_b.m0_ack};
    end
    check("alt_c0", 32'(seq[0]), 32'h0);
    check("alt_c1", 32'(seq[1]), 32'h1);
    check("alt_c2", 32'(seq[2]), 32'h2);
    check("alt_c3", 32'(seq[3]), 32'h1);
    check("alt_c4", 32'(seq[4]), 32'h2);
    @(posedge clk); #1;
    if_b.m0_req = 1'b0; if_b.m1_req = 1'b0;

    // Single RAM write
    run_txn(1'b0, 1'b1, 16'h8004, 32'hDEADBEEF, r);
    check("wr_ack", 32'(r.ack), 32'h1);
    check("wr_acyc", r.a_cyc, 1);
    check("wr_nwr", r.n_wr, 1);
    check("wr_nrd", r.n_rd, 0);
    check("wr_en", 32'(r.en), 32'h1);
    check("wr_addr", 32'(r.saddr), 32'h8004);
    check("wr_wdata", r.swdata, 32'hDEADBEEF);
    check("wr_err", 32'(r.err), 32'h0);

    // RAM read, 2-cycle latency
    run_txn(1'b0, 1'b0, 16'h8004, 32'h0, r);
    check("rd_ack", 32'(r.ack), 32'h1);
    check("rd_nrd", r.n_rd, 1);
    check("rd_nwr", r.n_wr, 0);
    check("rd_en", 32'(r.en), 32'h1);
    check("rd_lat", r.a_cyc - r.s_cyc, 2);
    check("rd_data", r.rdata, 32'hDEADBEEF);
    check("rd_err", 32'(r.err), 32'h0);
    @(negedge clk);
    check("rd_hold", if_a.m0_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // m0 streams writes; m1 must wait exactly MAX_HOLD=4 m0 acks
    if_a.m0_req = 1'b1; if_a.m0_wr = 1'b1; if_a.m0_addr = 16'h8001; if_a.m0_wdata = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    if_a.m1_req = 1'b1; if_a.m1_wr = 1'b1; if_a.m1_addr = 16'h8002; if_a.m1_wdata = 32'h2;
    n0 = 0;
    got1 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (if_a.m1_ack) begin
        got1 = 1'b1;
        break;
      end
      if (if_a.m0_ack) n0++;
    end
    check("hold_m0_acks", n0, 4);
    check("hold_m1_ack", 32'(got1), 32'h1);
    @(posedge clk); #1;
    if_a.m0_req = 1'b0; if_a.m1_req = 1'b0;
    @(posedge clk); #1;

    // Error cases and TTY
    run_txn(1'b1, 1'b1, 16'h0010, 32'h55, r);
    check("romwr_ack", 32'(r.ack), 32'h1);
    check("romwr_err", 32'(r.err), 32'h1);
    check("romwr_strb", r.n_rd + r.n_wr, 0);
    check("romwr_en", 32'(r.en), 32'h0);
    run_txn(1'b1, 1'b0, 16'h5000, 32'h0, r);
    check("unmap_ack", 32'(r.ack), 32'h1);
    check("unmap_err", 32'(r.err), 32'h1);
    check("unmap_strb", r.n_rd + r.n_wr, 0);
    check("unmap_en", 32'(r.en), 32'h0);
    run_txn(1'b0, 1'b1, 16'h4000, 32'h41, r);
    check("tty_ack", 32'(r.ack), 32'h1);
    check("tty_err", 32'(r.err), 32'h0);
    check("tty_nwr", r.n_wr, 1);
    check("tty_en", 32'(r.en), 32'h4);
    check("tty_wdata", r.swdata, 32'h41);
    run_txn(1'b0, 1'b0, 16'h4000, 32'h0, r);
    check("ttyrd_ack", 32'(r.ack), 32'h1);
    check("ttyrd_err", 32'(r.err), 32'h0);
    check("ttyrd_data", r.rdata, 32'h0);

    // m1 writes RAM word 3, then m0 reads ROM 0x0003 (model aliases addr[3:0])
    run_txn(1'b1, 1'b1, 16'h8003, 32'h12345678, r);
    check("m1wr_ack", 32'(r.ack), 32'h1);
    run_txn(1'b0, 1'b0, 16'h0003, 32'h0, r);
    check("romrd_en", 32'(r.en), 32'h2);
    check("romrd_nrd", r.n_rd, 1);
    check("romrd_err", 32'(r.err), 32'h0);
    check("romrd_data", r.rdata, 32'h12345678);

    // Reset during WAIT aborts the read with no ack
    if_a.m0_req = 1'b1; if_a.m0_wr = 1'b0; if_a.m0_addr = 16'h8004;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if_a.bus_rd) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_strobe", 32'(seen), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_zero("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    if_a.m0_req = 1'b0;
    @(posedge clk); #1;
    run_txn(1'b1, 1'b1, 16'h8008, 32'hCAFE0001, r);
    check("post_ack", 32'(r.ack), 32'h1);
    check("post_acyc", r.a_cyc, 1);
    check("post_nwr", r.n_wr, 1);
    check("post_addr", 32'(r.saddr), 32'h8008);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
